// File: rtl/picorv32_pcpi_hub.sv
// picorv32_pcpi_hub
//   Sits between the PicoRV32 PCPI master port and two PCPI coprocessors
//   (slot 0: multiplier, slot 1: divider). A core request is registered and
//   broadcast to every enabled slot with operands held stable. The hub then
//   tracks which slot claims it, captures the result and returns a one-cycle
//   response. It also flags instructions nobody claims and double claims.
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   pcpi_valid/insn/rs1/rs2     request from the core
//   pcpi_wr/rd/wait/ready       response to the core (all registered)
//   s_valid[1:0]                per-slot request valid
//   s_insn/s_rs1/s_rs2          held request, shared by both slots
//   s_wr/s_rd/s_wait/s_ready    per-slot responses, slot n result on s_rd[32n+:32]
//   unclaimed                   one-cycle pulse when no slot claims in time
//   conflict                    one-cycle pulse when both slots claim together
module picorv32_pcpi_hub #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [1:0]  SLOT_MASK = 2'b11
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready,
  output logic [1:0]  s_valid,
  output logic [31:0] s_insn,
  output logic [31:0] s_rs1,
  output logic [31:0] s_rs2,
  input  logic [1:0]  s_wr,
  input  logic [63:0] s_rd,
  input  logic [1:0]  s_wait,
  input  logic [1:0]  s_ready,
  output logic        unclaimed,
  output logic        conflict
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  // Counter value at which an unclaimed instruction is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 32'd1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        claim_q, claim_d;
  logic [1:0]  s_valid_q, s_valid_d;
  logic [31:0] s_insn_q, s_insn_d;
  logic [31:0] s_rs1_q, s_rs1_d;
  logic [31:0] s_rs2_q, s_rs2_d;
  logic        pcpi_wr_q, pcpi_wr_d;
  logic [31:0] pcpi_rd_q, pcpi_rd_d;
  logic        pcpi_wait_q, pcpi_wait_d;
  logic        pcpi_ready_q, pcpi_ready_d;
  logic        unclaimed_q, unclaimed_d;
  logic        conflict_q, conflict_d;

  // Disabled slots never contribute a claim.
  logic [1:0] rdy_en_s;
  logic [1:0] wait_en_s;
  logic       rdy_sel_s;
  logic       wait_sel_s;

  // Result slice of one slot.
  function automatic logic [31:0] slot_rd(input logic [63:0] rd, input logic sel);
    slot_rd = sel ? rd[63:32] : rd[31:0];
  endfunction

  assign rdy_en_s   = s_ready & SLOT_MASK;
  assign wait_en_s  = s_wait  & SLOT_MASK;
  // Slot 0 wins every tie.
  assign rdy_sel_s  = ~rdy_en_s[0];
  assign wait_sel_s = ~wait_en_s[0];

  // Next-state and registered-output logic of the request FSM.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    claim_d      = claim_q;
    s_valid_d    = s_valid_q;
    s_insn_d     = s_insn_q;
    s_rs1_d      = s_rs1_q;
    s_rs2_d      = s_rs2_q;
    pcpi_wr_d    = 1'b0;
    pcpi_rd_d    = pcpi_rd_q;
    pcpi_wait_d  = pcpi_wait_q;
    pcpi_ready_d = 1'b0;
    unclaimed_d  = 1'b0;
    conflict_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pcpi_valid) begin
          s_insn_d  = pcpi_insn;
          s_rs1_d   = pcpi_rs1;
          s_rs2_d   = pcpi_rs2;
          s_valid_d = SLOT_MASK;
          cnt_d     = 8'd0;
          state_d   = ST_ISSUE;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_d = cnt_q + 8'd1;
        if (!pcpi_valid) begin
          s_valid_d   = 2'b00;
          pcpi_wait_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (|rdy_en_s) begin
          // Ready outranks any wait seen in the same cycle.
          pcpi_wr_d    = s_wr[rdy_sel_s];
          pcpi_rd_d    = slot_rd(s_rd, rdy_sel_s);
          pcpi_ready_d = 1'b1;
          conflict_d   = &rdy_en_s;
          s_valid_d    = 2'b00;
          state_d      = ST_DONE;
        end else if (|wait_en_s) begin
          claim_d     = wait_sel_s;
          conflict_d  = &wait_en_s;
          pcpi_wait_d = 1'b1;
          state_d     = ST_WAIT;
        end else if (cnt_q == TO_LAST) begin
          // The core sees no ready and takes its illegal-instruction path.
          s_valid_d   = 2'b00;
          unclaimed_d = 1'b1;
          state_d     = ST_HOLD;
        end else begin
          state_d     = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        // Counter frozen: a claimed instruction may run arbitrarily long.
        if (!pcpi_valid) begin
          s_valid_d   = 2'b00;
          pcpi_wait_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (s_ready[claim_q]) begin
          pcpi_wr_d    = s_wr[claim_q];
          pcpi_rd_d    = slot_rd(s_rd, claim_q);
          pcpi_ready_d = 1'b1;
          pcpi_wait_d  = 1'b0;
          s_valid_d    = 2'b00;
          state_d      = ST_DONE;
        end else begin
          state_d      = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        // A valid that lingers after the response must not re-issue.
        if (!pcpi_valid) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        s_valid_d   = 2'b00;
        pcpi_wait_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      claim_q      <= 1'b0;
      s_valid_q    <= 2'b00;
      s_insn_q     <= 32'd0;
      s_rs1_q      <= 32'd0;
      s_rs2_q      <= 32'd0;
      pcpi_wr_q    <= 1'b0;
      pcpi_rd_q    <= 32'd0;
      pcpi_wait_q  <= 1'b0;
      pcpi_ready_q <= 1'b0;
      unclaimed_q  <= 1'b0;
      conflict_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      claim_q      <= claim_d;
      s_valid_q    <= s_valid_d;
      s_insn_q     <= s_insn_d;
      s_rs1_q      <= s_rs1_d;
      s_rs2_q      <= s_rs2_d;
      pcpi_wr_q    <= pcpi_wr_d;
      pcpi_rd_q    <= pcpi_rd_d;
      pcpi_wait_q  <= pcpi_wait_d;
      pcpi_ready_q <= pcpi_ready_d;
      unclaimed_q  <= unclaimed_d;
      conflict_q   <= conflict_d;
    end
  end

  assign pcpi_wr    = pcpi_wr_q;
  assign pcpi_rd    = pcpi_rd_q;
  assign pcpi_wait  = pcpi_wait_q;
  assign pcpi_ready = pcpi_ready_q;
  assign s_valid    = s_valid_q;
  assign s_insn     = s_insn_q;
  assign s_rs1      = s_rs1_q;
  assign s_rs2      = s_rs2_q;
  assign unclaimed  = unclaimed_q;
  assign conflict   = conflict_q;

endmodule

// File: tb/tb_picorv32_pcpi_hub.sv
module tb_picorv32_pcpi_hub;

  logic        clk;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic [1:0]  s_valid;
  logic [31:0] s_insn;
  logic [31:0] s_rs1;
  logic [31:0] s_rs2;
  logic [1:0]  s_wr;
  logic [63:0] s_rd;
  logic [1:0]  s_wait;
  logic [1:0]  s_ready;
  logic        unclaimed;
  logic        conflict;

  picorv32_pcpi_hub #(.TIMEOUT(16), .SLOT_MASK(2'b11)) dut (
    .clk(clk), .resetn(resetn),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready),
    .s_valid(s_valid), .s_insn(s_insn), .s_rs1(s_rs1), .s_rs2(s_rs2),
    .s_wr(s_wr), .s_rd(s_rd), .s_wait(s_wait), .s_ready(s_ready),
    .unclaimed(unclaimed), .conflict(conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [31:0] rd;
  } exp_t;

  exp_t exp_q[$];

  int tests_run  = 0;
  int tests_fail = 0;
  int ready_cnt  = 0;
  int wait_cnt   = 0;
  int uncl_cnt   = 0;
  int conf_cnt   = 0;
  int base_rdy, base_wait, base_uncl, base_conf;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // One clock: sample #1 after the edge, score any response against the queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (pcpi_ready === 1'b1) begin
      ready_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_rd", pcpi_rd, e.rd);
        check_eq("sb_wr", 32'(pcpi_wr), 32'(e.wr));
      end
    end
    if (pcpi_wait === 1'b1) wait_cnt++;
    if (unclaimed === 1'b1) uncl_cnt++;
    if (conflict === 1'b1) conf_cnt++;
  endtask

  task automatic mark();
    base_rdy  = ready_cnt;
    base_wait = wait_cnt;
    base_uncl = uncl_cnt;
    base_conf = conf_cnt;
  endtask

  task automatic slots_idle();
    s_wr    = 2'b00;
    s_rd    = 64'd0;
    s_wait  = 2'b00;
    s_ready = 2'b00;
  endtask

  task automatic core_req(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    pcpi_valid = 1'b1;
    pcpi_insn  = insn;
    pcpi_rs1   = rs1;
    pcpi_rs2   = rs2;
  endtask

  initial begin
    resetn     = 1'b0;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'd0;
    pcpi_rs1   = 32'd0;
    pcpi_rs2   = 32'd0;
    slots_idle();
    step();
    step();
    check_eq("rst_outputs",
             {22'd0, pcpi_wr, pcpi_wait, pcpi_ready, s_valid, unclaimed, conflict, 3'd0}, 32'd0);
    check_eq("rst_rd", pcpi_rd, 32'd0);
    resetn = 1'b1;
    step();

    // MUL: slot 0 answers two cycles after s_valid.
    mark();
    core_req(32'h02208033, 32'd7, 32'd6);
    exp_q.push_back('{wr: 1'b1, rd: 32'd42});
    step();
    check_eq("mul_svalid", 32'(s_valid), 32'd3);
    check_eq("mul_sinsn", s_insn, 32'h02208033);
    step();
    s_ready = 2'b01; s_wr = 2'b01; s_rd = {32'd0, 32'd42};
    step();
    check_eq("mul_ready", 32'(pcpi_ready), 32'd1);
    check_eq("mul_svalid_drop", 32'(s_valid), 32'd0);
    slots_idle();
    step();
    check_eq("mul_ready_1cyc", 32'(pcpi_ready), 32'd0);
    check_eq("mul_rd_hold", pcpi_rd, 32'd42);
    pcpi_valid = 1'b0;
    step();
    check_eq("mul_ready_cnt", 32'(ready_cnt - base_rdy), 32'd1);
    check_eq("mul_wait_cnt", 32'(wait_cnt - base_wait), 32'd0);
    check_eq("mul_conf_cnt", 32'(conf_cnt - base_conf), 32'd0);

    // DIV: slot 1 waits from edge 2, answers at edge 35.
    mark();
    core_req(32'h0220C033, 32'd100, 32'd7);
    exp_q.push_back('{wr: 1'b1, rd: 32'd14});
    step();
    step();
    s_wait = 2'b10;
    for (int i = 2; i <= 34; i++) step();
    check_eq("div_wait_held", 32'(pcpi_wait), 32'd1);
    s_ready = 2'b10; s_wr = 2'b10; s_rd = {32'd14, 32'd0};
    step();
    check_eq("div_ready", 32'(pcpi_ready), 32'd1);
    check_eq("div_wait_drop", 32'(pcpi_wait), 32'd0);
    slots_idle();
    pcpi_valid = 1'b0;
    step();
    step();
    check_eq("div_wait_cycles", 32'(wait_cnt - base_wait), 32'd33);
    check_eq("div_no_timeout", 32'(uncl_cnt - base_uncl), 32'd0);
    check_eq("div_ready_cnt", 32'(ready_cnt - base_rdy), 32'd1);

    // Unclaimed: nobody answers, timeout 16 cycles after s_valid rises.
    mark();
    core_req(32'h0000000B, 32'd1, 32'd2);
    step();
    for (int i = 1; i <= 15; i++) step();
    check_eq("uncl_early", 32'(uncl_cnt - base_uncl), 32'd0);
    check_eq("uncl_svalid_before", 32'(s_valid), 32'd3);
    step();
    check_eq("uncl_pulse", 32'(unclaimed), 32'd1);
    check_eq("uncl_svalid_drop", 32'(s_valid), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check_eq("uncl_hold_svalid", 32'(s_valid), 32'd0);
    check_eq("uncl_pulse_cnt", 32'(uncl_cnt - base_uncl), 32'd1);
    check_eq("uncl_no_ready", 32'(ready_cnt - base_rdy), 32'd0);
    pcpi_valid = 1'b0;
    step();
    step();

    // Conflict: both ready together, slot 0 wins.
    mark();
    core_req(32'h02208033, 32'd3, 32'd4);
    exp_q.push_back('{wr: 1'b1, rd: 32'h11});
    step();
    s_ready = 2'b11; s_wr = 2'b11; s_rd = {32'h22, 32'h11};
    step();
    check_eq("conf_pulse", 32'(conflict), 32'd1);
    slots_idle();
    pcpi_valid = 1'b0;
    step();
    step();
    check_eq("conf_cnt", 32'(conf_cnt - base_conf), 32'd1);

    // Abort while in WAIT.
    mark();
    core_req(32'h0220C033, 32'd9, 32'd3);
    step();
    s_wait = 2'b10;
    step();
    check_eq("abort_wait_set", 32'(pcpi_wait), 32'd1);
    pcpi_valid = 1'b0;
    step();
    check_eq("abort_svalid", 32'(s_valid), 32'd0);
    check_eq("abort_wait", 32'(pcpi_wait), 32'd0);
    s_ready = 2'b10; s_wr = 2'b10; s_rd = {32'h55, 32'd0};
    step();
    step();
    slots_idle();
    check_eq("abort_no_ready", 32'(ready_cnt - base_rdy), 32'd0);

    // Reset mid-WAIT.
    core_req(32'h02208033, 32'd1, 32'd1);
    step();
    s_wait = 2'b01;
    step();
    step();
    check_eq("rstw_wait_set", 32'(pcpi_wait), 32'd1);
    resetn = 1'b0;
    step();
    check_eq("rstw_outputs",
             {22'd0, pcpi_wr, pcpi_wait, pcpi_ready, s_valid, unclaimed, conflict, 3'd0}, 32'd0);
    check_eq("rstw_rd", pcpi_rd, 32'd0);
    resetn = 1'b1;
    pcpi_valid = 1'b0;
    slots_idle();
    step();

    // Held operands, wr=0 response, lingering valid must not re-issue.
    mark();
    core_req(32'h02209033, 32'd5, 32'd3);
    exp_q.push_back('{wr: 1'b0, rd: 32'h99});
    step();
    pcpi_rs1 = 32'hDEAD;
    step();
    check_eq("held_rs1", s_rs1, 32'd5);
    s_ready = 2'b01; s_wr = 2'b00; s_rd = {32'd0, 32'h99};
    step();
    slots_idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("no_reissue", 32'(s_valid), 32'd0);
    end
    pcpi_valid = 1'b0;
    step();
    check_eq("no_reissue_low", 32'(s_valid), 32'd0);
    core_req(32'h02208033, 32'hDEAD, 32'd1);
    exp_q.push_back('{wr: 1'b1, rd: 32'd7});
    step();
    check_eq("reissue_svalid", 32'(s_valid), 32'd3);
    check_eq("reissue_rs1", s_rs1, 32'hDEAD);
    s_ready = 2'b01; s_wr = 2'b01; s_rd = {32'd0, 32'd7};
    step();
    slots_idle();
    pcpi_valid = 1'b0;
    step();
    step();
    check_eq("held_ready_cnt", 32'(ready_cnt - base_rdy), 32'd2);
    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
    $finish;
  end

endmodule
